// File: rtl/pov_frame_reader_if.sv
// Bus bundle for the POV frame reader: Avalon-MM read port toward the RAM
// and valid/ready pixel stream toward the LED column driver.
interface pov_frame_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid,
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid,
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/pov_frame_reader.sv
// Avalon-MM read master fetching a contiguous, wrapping block of pixel words
// into a small show-ahead FIFO that feeds the POV LED stream.
module pov_frame_reader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MEM_WORDS  = 2560,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  pov_frame_reader_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
  localparam logic [CNT_W:0]    OCC_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   retired;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [CNT_W:0]    occupancy;

  logic rd_req;
  logic accept;
  logic push;
  logic pop;
  logic last_pop;
  logic last_issue;
  logic fifo_empty;
  logic capture;
  logic zero_start;
  logic done_nxt;

  // Occupancy counts every word fetched but not yet consumed, so holding it
  // below FIFO_DEPTH guarantees a slot for each returning beat.
  assign occupancy  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign fifo_empty = (fifo_count == '0);
  assign accept     = rd_req && !bus.avm_waitrequest;
  assign push       = bus.avm_readdatavalid && (outstanding != '0);
  assign pop        = !fifo_empty && bus.pix_ready;
  assign last_pop   = pop && ((retired + (ADDR_W + 1)'(1)) == count);
  assign last_issue = accept && ((issued + (ADDR_W + 1)'(1)) == count);
  assign capture    = (state == IDLE) && start && (word_count != '0);
  assign zero_start = (state == IDLE) && start && (word_count == '0);

  assign bus.avm_address = addr;
  assign bus.avm_read    = rd_req;
  assign bus.pix_valid   = !fifo_empty;
  assign bus.pix_data    = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign busy            = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture)    state_nxt = RUN;
        if (zero_start) done_nxt  = 1'b1;
      end
      RUN: begin
        rd_req = (issued != count) && (occupancy < OCC_LIMIT);
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_pop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr    <= '0;
      count   <= '0;
      issued  <= '0;
      retired <= '0;
    end else if (capture) begin
      addr    <= base_addr;
      count   <= {1'b0, word_count};
      issued  <= '0;
      retired <= '0;
    end else begin
      if (accept) begin
        addr   <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
        issued <= issued + (ADDR_W + 1)'(1);
      end
      if (pop) retired <= retired + (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      unique case ({accept, push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.avm_readdata;
  end

  a_occupancy_bound : assert property (@(posedge clk) disable iff (!reset_n)
    occupancy <= OCC_LIMIT);

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!reset_n)
    push |-> ((fifo_count != CNT_W'(FIFO_DEPTH)) || pop));

  a_hold_under_wait : assert property (@(posedge clk) disable iff (!reset_n)
    (bus.avm_read && bus.avm_waitrequest) |=> (bus.avm_read && $stable(bus.avm_address)));

endmodule

// File: tb/tb_pov_frame_reader.sv
// Self-checking bench for pov_frame_reader: behavioural RAM slave, stream sink
// and a word-sequence reference model built from base/count arithmetic.
module tb_pov_frame_reader;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int MEM_WORDS  = 2560;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] word_count = '0;
  logic              busy;
  logic              done;

  pov_frame_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pov_frame_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return 32'hA500_0000 + {20'h0, a};
  endfunction

  // Reference model: the ordered addresses and words one transfer must produce
  logic [ADDR_W-1:0] exp_addr [$];
  logic [DATA_W-1:0] exp_data [$];

  int cyc = 0;
  int acc_cnt, pop_cnt, done_cnt, hold_viol, max_inflight;
  int first_acc_cyc, first_val_cyc, last_pop_cyc, done_cyc, start_cyc;
  int ready_mode = 0;
  int stall_idx = -1;
  int stall_left = 0;
  bit wait_rand = 1'b0;
  bit read_seen;
  bit prev_stall = 1'b0;
  bit w_now, r_now;
  logic [ADDR_W-1:0] prev_addr;

  always @(posedge clk) cyc++;

  // RAM slave with a read latency of one cycle
  always @(posedge clk) begin
    bus.avm_readdatavalid <= bus.avm_read && !bus.avm_waitrequest;
    bus.avm_readdata <= (bus.avm_read && !bus.avm_waitrequest) ?
                        ram_word(bus.avm_address) : 32'hDEAD_BEEF;
  end

  // Mid-cycle: observe this cycle's outputs, choose this cycle's inputs
  always @(negedge clk) begin
    if (!reset_n) begin
      bus.avm_waitrequest = 1'b0;
      bus.pix_ready       = 1'b0;
      prev_stall          = 1'b0;
    end else begin
      w_now = 1'b0;
      if (bus.avm_read) begin
        if (stall_left > 0 && acc_cnt == stall_idx) begin
          w_now = 1'b1;
          stall_left--;
        end else if (wait_rand) begin
          w_now = ($urandom_range(0, 3) == 0);
        end
      end
      case (ready_mode)
        0:       r_now = 1'b1;
        1:       r_now = (cyc % 3 == 0);
        default: r_now = 1'($urandom_range(0, 1));
      endcase
      bus.avm_waitrequest = w_now;
      bus.pix_ready       = r_now;

      if (bus.avm_read) read_seen = 1'b1;
      if (prev_stall && !(bus.avm_read && bus.avm_address == prev_addr)) hold_viol++;
      prev_stall = bus.avm_read && w_now;
      prev_addr  = bus.avm_address;

      if (bus.avm_read && !w_now) begin
        if (acc_cnt == 0) first_acc_cyc = cyc;
        acc_cnt++;
        if (exp_addr.size() == 0) report_fail("extra_read_addr", 64'(bus.avm_address));
        else check("bus_addr", 64'(bus.avm_address), 64'(exp_addr.pop_front()));
        if (acc_cnt - pop_cnt > max_inflight) max_inflight = acc_cnt - pop_cnt;
      end
      if (bus.pix_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (bus.pix_valid && r_now) begin
        if (exp_data.size() == 0) report_fail("extra_pix_word", 64'(bus.pix_data));
        else check("pix_data", 64'(bus.pix_data), 64'(exp_data.pop_front()));
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(input int unsigned b, input int unsigned n);
    int unsigned a;
    exp_addr.delete();
    exp_data.delete();
    for (int unsigned i = 0; i < n; i++) begin
      a = (b + i) % MEM_WORDS;
      exp_addr.push_back(ADDR_W'(a));
      exp_data.push_back(ram_word(ADDR_W'(a)));
    end
    acc_cnt = 0; pop_cnt = 0; done_cnt = 0; hold_viol = 0; max_inflight = 0;
    first_acc_cyc = -1; first_val_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    read_seen = 1'b0;
    base_addr  = ADDR_W'(b);
    word_count = ADDR_W'(n);
    start      = 1'b1;
    start_cyc  = cyc;
    step();
    start      = 1'b0;
    base_addr  = ADDR_W'($urandom);
    word_count = ADDR_W'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < budget) begin
      if (done) ok = 1'b1;
      else begin
        step();
        i++;
      end
    end
  endtask

  task automatic finish_check(input string name, input int unsigned n, input int exp_cyc,
                              input bit expect_full, input bit pulse_check);
    bit ok;
    wait_done(int'(n) * 20 + 200, ok);
    check({name, ":done_seen"}, 64'(ok), 64'(1));
    check({name, ":busy_at_done"}, 64'(busy), 64'(0));
    check({name, ":reads"}, 64'(acc_cnt), 64'(n));
    check({name, ":pops"}, 64'(pop_cnt), 64'(n));
    check({name, ":leftover_words"}, 64'(exp_data.size()), 64'(0));
    check({name, ":done_after_last_pop"}, 64'(done_cyc - last_pop_cyc), 64'(1));
    check({name, ":first_valid_latency"}, 64'(first_val_cyc - first_acc_cyc), 64'(2));
    check({name, ":waitreq_hold"}, 64'(hold_viol), 64'(0));
    if (expect_full) check({name, ":inflight_peak"}, 64'(max_inflight), 64'(FIFO_DEPTH));
    else check({name, ":inflight_bound"}, 64'(max_inflight <= FIFO_DEPTH), 64'(1));
    if (exp_cyc >= 0) check({name, ":start_to_done"}, 64'(done_cyc - start_cyc), 64'(exp_cyc));
    if (pulse_check) begin
      step();
      check({name, ":done_pulse"}, 64'(done), 64'(0));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ":busy"}, 64'(busy), 64'(0));
    check({name, ":done"}, 64'(done), 64'(0));
    check({name, ":avm_read"}, 64'(bus.avm_read), 64'(0));
    check({name, ":avm_address"}, 64'(bus.avm_address), 64'(0));
    check({name, ":pix_valid"}, 64'(bus.pix_valid), 64'(0));
    check({name, ":pix_data"}, 64'(bus.pix_data), 64'(0));
  endtask

  typedef struct {
    string       name;
    int unsigned base;
    int unsigned count;
    int          ready_mode;
    int          stall_idx;
    int          stall_len;
    int          exp_cycles;
    bit          expect_full;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit ok;
    int unsigned rb, rn;

    vecs[0] = '{"basic",       32'h010, 8,    0, -1, 0, 11,   1'b0};
    vecs[1] = '{"wrap",        2558,    4,    0, -1, 0, 7,    1'b0};
    vecs[2] = '{"backpress",   32'h100, 16,   1, -1, 0, -1,   1'b1};
    vecs[3] = '{"waitreq",     32'h200, 6,    0, 1,  3, 12,   1'b0};
    vecs[4] = '{"single_last", 2559,    1,    0, -1, 0, 4,    1'b0};
    vecs[5] = '{"pair_zero",   0,       2,    0, -1, 0, 5,    1'b0};
    vecs[6] = '{"max_count",   5,       4095, 0, -1, 0, 4098, 1'b0};

    #1 reset_n = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      ready_mode = vecs[i].ready_mode;
      stall_idx  = vecs[i].stall_idx;
      stall_left = vecs[i].stall_len;
      launch(vecs[i].base, vecs[i].count);
      finish_check(vecs[i].name, vecs[i].count, vecs[i].exp_cycles,
                   vecs[i].expect_full, 1'b1);
    end
    ready_mode = 0;
    stall_idx  = -1;
    stall_left = 0;

    // Zero-length request: immediate done, no bus traffic
    launch(100, 0);
    check("zero:done", 64'(done), 64'(1));
    check("zero:busy", 64'(busy), 64'(0));
    step();
    check("zero:done_pulse", 64'(done), 64'(0));
    check("zero:no_read", 64'(read_seen), 64'(0));
    check("zero:done_count", 64'(done_cnt), 64'(1));

    // Start during a transfer must not disturb it
    launch(32'h300, 12);
    repeat (4) step();
    start = 1'b1; base_addr = 12'h050; word_count = 12'd3;
    step();
    start = 1'b0;
    finish_check("ignore_start", 12, -1, 1'b0, 1'b1);

    // Back-to-back start in the done cycle
    launch(32'h020, 5);
    wait_done(300, ok);
    check("b2b:first_done", 64'(ok), 64'(1));
    check("b2b:first_pops", 64'(pop_cnt), 64'(5));
    launch(32'h030, 3);
    finish_check("b2b_second", 3, 6, 1'b0, 1'b1);

    // Reset in the middle of a transfer
    launch(32'h400, 10);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (pop_cnt >= 3) ok = 1'b1;
      else step();
    end
    check("midreset:three_words", 64'(ok), 64'(1));
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    step();
    reset_n = 1'b1;
    repeat (6) step();
    check("midreset:no_done", 64'(done_cnt), 64'(0));
    check("midreset:idle_busy", 64'(busy), 64'(0));
    launch(32'h7F0, 5);
    finish_check("after_reset", 5, 8, 1'b0, 1'b1);

    // Randomised transfers with random stalls and backpressure
    ready_mode = 2;
    wait_rand  = 1'b1;
    for (int t = 0; t < 20; t++) begin
      rb = $urandom_range(0, MEM_WORDS - 1);
      rn = $urandom_range(1, 40);
      launch(rb, rn);
      finish_check("rand", rn, -1, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pov_frame_reader.md
# pov_frame_reader

Avalon-MM read master that fetches a contiguous block of 32-bit pixel words from the on-chip RAM and presents them as a valid/ready stream to the LED column driver. Software or the rotation sequencer pulses `start` with a base word address and a word count. The block issues pipelined reads, buffers returned data in a small FIFO, and pulses `done` when the last word has been consumed downstream. It sits between the on-chip RAM port and the POV LED shift logic.

## Interface
- `ADDR_W`, 12, word-address width of RAM port
- `DATA_W`, 32, data width
- `MEM_WORDS`, 2560, RAM depth; addresses wrap modulo this value
- `FIFO_DEPTH`, 4, output FIFO entries (power of 2, ≥2); also bounds outstanding reads
- `clk`  in  1  single clock for all logic
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request pulse; sampled only when idle
- `base_addr`  in  ADDR_W  first word address, captured on accepted `start`
- `word_count`  in  ADDR_W  number of words to read, captured on accepted `start`
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse after last word handed off
- `avm_address`  out  ADDR_W  word address
- `avm_read`  out  1  read request
- `avm_waitrequest`  in  1  slave stall; hold address/read while high
- `avm_readdata`  in  DATA_W  returned data
- `avm_readdatavalid`  in  1  `avm_readdata` valid this cycle
- `pix_data`  out  DATA_W  stream data
- `pix_valid`  out  1  stream data valid
- `pix_ready`  in  1  downstream accepts when high with `pix_valid`

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: `start`=1 with `word_count`≠0 → RUN. Capture addr and count; `issued`=0, `retired`=0.
  - IDLE: `start`=1 with `word_count`=0 → stay IDLE; pulse `done` next cycle; no bus activity.
  - RUN: issue reads. When `issued`==count and last request accepted → DRAIN.
  - DRAIN: wait for all data returned and FIFO empty with last word accepted → IDLE; pulse `done`.
- Read issue rule:
  - `avm_read`=1 in RUN when `outstanding + fifo_count < FIFO_DEPTH`.
  - `outstanding` = accepted reads not yet returned via `readdatavalid`.
  - Request is accepted on a cycle with `avm_read`=1 and `avm_waitrequest`=0.
  - On acceptance: address += 1, wrapping `MEM_WORDS-1` → 0; `issued` += 1.
  - While `avm_waitrequest`=1, `avm_address` and `avm_read` are held stable.
- Every `readdatavalid` beat is written into the FIFO. Overflow cannot occur by construction; the assertion `outstanding+fifo_count ≤ FIFO_DEPTH` must hold.
- FIFO is show-ahead: `pix_valid` = FIFO non-empty; `pix_data` = head entry.
- Pop occurs on `pix_valid & pix_ready`. A simultaneous push and pop keeps the count unchanged. Data order is preserved.
- `start` while `busy`=1 is ignored; captured parameters do not change.
- Counters are ADDR_W+1 bits wide, so `word_count` = 2^ADDR_W−1 does not overflow.

## Timing
- Reset values, applied asynchronously on `reset_n`=0:
  - state IDLE
  - `busy`=0, `done`=0, `avm_read`=0, `avm_address`=0
  - `pix_valid`=0, `pix_data`=0
  - FIFO empty; all counters 0
- Reset mid-operation aborts the transfer immediately. Late `readdatavalid` beats after reset release are discarded, because `outstanding` is 0 in IDLE.
- `start` sampled at edge N: `busy`=1 and `avm_read`=1 from cycle N+1, with `avm_address`=`base_addr`.
- RAM read latency is 1: `readdatavalid` arrives the cycle after acceptance. The FIFO write is registered, so `pix_valid` rises 2 cycles after the first accepted read.
- Steady state with `waitrequest`=0 and `pix_ready`=1: one word per cycle.
- `done` is asserted the cycle after the final pop. `busy` falls in the same cycle `done` rises.
- A back-to-back `start` is accepted in the cycle `done` is high, since the FSM is already IDLE.

## Test plan
- **Basic read:** RAM preloaded with word[i] = 0xA5000000+i. Apply `start`, `base_addr`=0x010, `word_count`=8, `pix_ready`=1.
  - Expect `pix_data` 0xA5000010..0xA5000017 in order, one per cycle.
  - Expect `done` 1 cycle after the last pop; 8 bus reads total.
- **Wrap-around:** `base_addr`=2558, `word_count`=4.
  - Expect addresses 2558, 2559, 0, 1 and data in that order.
- **Backpressure:** `word_count`=16, `pix_ready` toggling 1-of-3 cycles.
  - Expect no lost or duplicated word.
  - Expect `outstanding+fifo_count` never above 4; `avm_read` stalls while the FIFO is full.
- **Waitrequest:** slave asserts `avm_waitrequest` for 3 cycles on the 2nd read.
  - Expect `avm_address`=base+1 held stable throughout; final data sequence correct.
- **Edge controls:**
  - `word_count`=0: expect no `avm_read` and a single `done` pulse.
  - `start` pulsed mid-transfer: expect it ignored.
- **Reset mid-op:** assert `reset_n`=0 after 3 words of a 10-word read.
  - Expect all outputs at reset values and no `done`.
  - A new `start` afterwards must complete normally.
